// File: rtl/eth_avalon_txbd_fetch.sv
// TX buffer-descriptor engine on port B of the dual-port BD RAM.
// Walks the TX ring, fetches both words of each ready descriptor, offers it
// to the TX DMA, then writes back the completion status with RD cleared and
// raises the matching interrupt pulse.
module eth_avalon_txbd_fetch #(
    parameter int DEPTH       = 128,
    parameter int POLL_CYCLES = 16,
    localparam int AW         = $clog2(DEPTH),
    localparam int IW         = AW - 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          tx_en,
    input  logic [AW-1:0] tx_bd_num,
    output logic [AW-1:0] bd_address,
    output logic          bd_wren,
    output logic [31:0]   bd_wdata,
    input  logic [31:0]   bd_rdata,
    output logic          desc_valid,
    input  logic          desc_ready,
    output logic [15:0]   desc_len,
    output logic [31:0]   desc_ptr,
    output logic          desc_pad,
    output logic          desc_crc,
    input  logic          done_valid,
    input  logic [8:0]    done_status,
    output logic          txb_irq,
    output logic          txe_irq,
    output logic [IW-1:0] cur_bd
);

    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [AW-1:0] MAX_BDS   = AW'(DEPTH / 2);

    typedef enum logic [3:0] {
        IDLE,
        RD0,
        RD0_W,
        POLL,
        RD1,
        RD1_W,
        OFFER,
        BUSY,
        WB
    } state_t;

    state_t          state;
    logic [IW-1:0]   index;
    logic [PW-1:0]   poll_cnt;
    logic [31:0]     word0;
    logic [AW-1:0]   bd_limit;
    logic            last_bd;
    logic            frame_error;

    // Descriptor fields are presented straight from the captured word0.
    assign desc_len = word0[31:16];
    assign desc_pad = word0[12];
    assign desc_crc = word0[11];
    assign cur_bd   = index;

    // Clamp the ring size to what the RAM can hold and decide whether the
    // current descriptor is the last one of the ring; a count of zero also
    // wraps so the index can never run past a shrunken ring.
    always_comb begin
        bd_limit    = (tx_bd_num > MAX_BDS) ? MAX_BDS : tx_bd_num;
        last_bd     = (({1'b0, index} + AW'(1)) >= bd_limit);
        frame_error = done_status[8] | done_status[7] | done_status[6] | done_status[0];
    end

    // Ring walker: fetch, poll, offer, wait for completion, write back.
    // Addresses are registered one state early so the RAM's one-cycle read
    // latency lands bd_rdata exactly in the *_W capture states.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            index      <= '0;
            poll_cnt   <= '0;
            word0      <= '0;
            desc_ptr   <= '0;
            desc_valid <= 1'b0;
            bd_address <= '0;
            bd_wren    <= 1'b0;
            bd_wdata   <= '0;
            txb_irq    <= 1'b0;
            txe_irq    <= 1'b0;
        end else begin
            bd_wren <= 1'b0;
            txb_irq <= 1'b0;
            txe_irq <= 1'b0;
            case (state)
                IDLE: begin
                    if (!tx_en) begin
                        index <= '0;
                    end else if (tx_bd_num != '0) begin
                        bd_address <= {index, 1'b0};
                        state      <= RD0;
                    end
                end
                RD0: begin
                    state <= RD0_W;
                end
                RD0_W: begin
                    word0 <= bd_rdata;
                    if (!tx_en) begin
                        state <= IDLE;
                    end else if (!bd_rdata[15]) begin
                        poll_cnt <= '0;
                        state    <= POLL;
                    end else begin
                        bd_address <= {index, 1'b1};
                        state      <= RD1;
                    end
                end
                POLL: begin
                    if (!tx_en) begin
                        state <= IDLE;
                    end else if (poll_cnt == POLL_LAST) begin
                        bd_address <= {index, 1'b0};
                        state      <= RD0;
                    end else begin
                        poll_cnt <= poll_cnt + PW'(1);
                    end
                end
                RD1: begin
                    state <= RD1_W;
                end
                RD1_W: begin
                    desc_ptr   <= bd_rdata;
                    desc_valid <= 1'b1;
                    state      <= OFFER;
                end
                OFFER: begin
                    // A handshake seen by the DMA always wins over a late
                    // disable, otherwise the DMA would run an orphan frame.
                    if (desc_ready) begin
                        desc_valid <= 1'b0;
                        state      <= BUSY;
                    end else if (!tx_en) begin
                        desc_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                BUSY: begin
                    if (done_valid) begin
                        bd_wren    <= 1'b1;
                        bd_address <= {index, 1'b0};
                        bd_wdata   <= {word0[31:16], 1'b0, word0[14:9], done_status};
                        if (word0[14]) begin
                            txe_irq <= frame_error;
                            txb_irq <= ~frame_error;
                        end
                        state <= WB;
                    end
                end
                WB: begin
                    index <= (word0[13] || last_bd) ? '0 : index + IW'(1);
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_avalon_txbd_fetch.sv
// Self-checking bench for eth_avalon_txbd_fetch: directed ring scenarios
// followed by randomized frames, all checked against a descriptor-level
// model that predicts offers, writebacks, interrupts and the ring index.
module tb_eth_avalon_txbd_fetch;

    localparam int P = 4;

    logic        clock;
    logic        reset_n;
    logic        tx_en;
    logic [6:0]  tx_bd_num;
    logic [6:0]  bd_address;
    logic        bd_wren;
    logic [31:0] bd_wdata;
    logic [31:0] bd_rdata;
    logic        desc_valid;
    logic        desc_ready;
    logic [15:0] desc_len;
    logic [31:0] desc_ptr;
    logic        desc_pad;
    logic        desc_crc;
    logic        done_valid;
    logic [8:0]  done_status;
    logic        txb_irq;
    logic        txe_irq;
    logic [5:0]  cur_bd;

    logic [31:0] mem [0:127];
    int          num_compared;
    int          num_mismatched;
    bit          allow_wr;

    eth_avalon_txbd_fetch #(.DEPTH(128), .POLL_CYCLES(P)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .tx_en       (tx_en),
        .tx_bd_num   (tx_bd_num),
        .bd_address  (bd_address),
        .bd_wren     (bd_wren),
        .bd_wdata    (bd_wdata),
        .bd_rdata    (bd_rdata),
        .desc_valid  (desc_valid),
        .desc_ready  (desc_ready),
        .desc_len    (desc_len),
        .desc_ptr    (desc_ptr),
        .desc_pad    (desc_pad),
        .desc_crc    (desc_crc),
        .done_valid  (done_valid),
        .done_status (done_status),
        .txb_irq     (txb_irq),
        .txe_irq     (txe_irq),
        .cur_bd      (cur_bd)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Port B read path of the BD RAM; writebacks are checked in serve_frame
    // and the CPU side always rewrites a descriptor after it completes, so
    // the memory contents are owned by the stimulus process alone.
    always @(posedge clock) begin
        bd_rdata <= mem[bd_address];
    end

    // Hard stop in case a bounded wait was missed somewhere.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_compared++;
        if (obs !== exp) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // CPU hands a descriptor back to the engine with fresh random contents.
    task automatic rearm(input int idx);
        logic [31:0] w;
        w      = $urandom;
        w[15]  = 1'b1;
        w[13]  = allow_wr ? ($urandom_range(0, 3) == 0) : 1'b0;
        mem[2*idx]     = w;
        mem[2*idx + 1] = $urandom;
    endtask

    // Serve one descriptor as the DMA would and check the engine's side of it.
    task automatic serve_frame(input int idx, input int eff, input int ready_delay,
                               input int done_delay, input logic [8:0] status,
                               input bit drop_en, output int next_idx,
                               output logic [31:0] wb_word);
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] exp_wb;
        bit          err;
        int          waited;
        w0       = mem[2*idx];
        w1       = mem[2*idx + 1];
        exp_wb   = (w0 & 32'hFFFF_7E00) | {23'd0, status};
        err      = (status & 9'h1C1) != 9'h000;
        next_idx = (w0[13] || idx >= eff - 1) ? 0 : idx + 1;
        wb_word  = '0;
        waited   = 0;
        while (!desc_valid && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (!desc_valid) begin
            checkOutput("offer_timeout", {31'd0, desc_valid}, 32'd1);
            next_idx = idx;
            return;
        end
        checkOutput("offer_cur_bd", {26'd0, cur_bd}, idx);
        checkOutput("offer_len", {16'd0, desc_len}, {16'd0, w0[31:16]});
        checkOutput("offer_ptr", desc_ptr, w1);
        checkOutput("offer_pad", {31'd0, desc_pad}, {31'd0, w0[12]});
        checkOutput("offer_crc", {31'd0, desc_crc}, {31'd0, w0[11]});
        checkOutput("offer_no_wren", {31'd0, bd_wren}, 32'd0);
        for (int i = 0; i < ready_delay; i++) begin
            done_valid  = (i == 0 && ready_delay >= 2);
            done_status = 9'($urandom);
            @(negedge clock);
            done_valid = 1'b0;
            checkOutput("hold_valid", {31'd0, desc_valid}, 32'd1);
            checkOutput("hold_len", {16'd0, desc_len}, {16'd0, w0[31:16]});
            checkOutput("hold_ptr", desc_ptr, w1);
        end
        desc_ready = 1'b1;
        @(negedge clock);
        desc_ready = 1'b0;
        checkOutput("valid_drop", {31'd0, desc_valid}, 32'd0);
        for (int i = 0; i < done_delay; i++) begin
            tx_en = drop_en ? 1'b0 : 1'b1;
            @(negedge clock);
        end
        tx_en       = 1'b1;
        done_status = status;
        done_valid  = 1'b1;
        @(negedge clock);
        done_valid  = 1'b0;
        done_status = 9'($urandom);
        wb_word     = bd_wdata;
        checkOutput("wb_wren", {31'd0, bd_wren}, 32'd1);
        checkOutput("wb_addr", {25'd0, bd_address}, 2*idx);
        checkOutput("wb_data", bd_wdata, exp_wb);
        checkOutput("wb_txb", {31'd0, txb_irq}, {31'd0, w0[14] && !err});
        checkOutput("wb_txe", {31'd0, txe_irq}, {31'd0, w0[14] && err});
        @(negedge clock);
        checkOutput("post_wren", {31'd0, bd_wren}, 32'd0);
        checkOutput("post_irqs", {30'd0, txb_irq, txe_irq}, 32'd0);
        checkOutput("post_cur_bd", {26'd0, cur_bd}, next_idx);
        rearm(idx);
    endtask

    // Disable the engine and confirm it returns to the start of the ring.
    task automatic stop_engine();
        tx_en = 1'b0;
        repeat (8) @(negedge clock);
        checkOutput("disable_cur_bd", {26'd0, cur_bd}, 32'd0);
        checkOutput("disable_valid", {31'd0, desc_valid}, 32'd0);
    endtask

    // Randomized ring phases, one of them with an oversized BD count.
    task automatic applyStimulus();
        int          num;
        int          eff;
        int          idx;
        int          frames;
        logic [31:0] wb;
        for (int ph = 0; ph < 4; ph++) begin
            num      = (ph == 3) ? 100 : $urandom_range(1, 8);
            eff      = (num > 64) ? 64 : num;
            allow_wr = (ph != 3);
            frames   = (ph == 3) ? 66 : 12;
            for (int b = 0; b < eff; b++) rearm(b);
            tx_bd_num = 7'(num);
            tx_en     = 1'b1;
            idx       = 0;
            for (int f = 0; f < frames; f++) begin
                serve_frame(idx, eff, $urandom_range(0, 3), $urandom_range(0, 3),
                            9'($urandom_range(0, 511)), bit'($urandom_range(0, 1)), idx, wb);
            end
            stop_engine();
        end
        allow_wr = 1'b0;
    endtask

    initial begin
        int          next_idx;
        logic [31:0] wb;
        int          s;
        int          r;
        int          exp_n;
        int          seen;

        num_compared   = 0;
        num_mismatched = 0;
        allow_wr       = 1'b0;
        reset_n        = 1'b0;
        tx_en          = 1'b0;
        tx_bd_num      = 7'd8;
        desc_ready     = 1'b0;
        done_valid     = 1'b0;
        done_status    = '0;
        for (int a = 0; a < 128; a++) mem[a] = 32'd0;

        // Reset state.
        repeat (3) @(negedge clock);
        checkOutput("reset_outputs", {bd_wren, desc_valid, txb_irq, txe_irq, desc_pad, desc_crc, 26'd0}, 32'd0);
        checkOutput("reset_addr", {25'd0, bd_address}, 32'd0);
        checkOutput("reset_cur_bd", {26'd0, cur_bd}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Single frame with exact fetch latency.
        mem[0] = 32'h0040_D800;
        mem[1] = 32'h0000_1000;
        mem[2] = 32'h0020_8000;
        mem[3] = 32'hABCD_0000;
        tx_en  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            checkOutput("latency_valid", {31'd0, desc_valid}, (c == 5) ? 32'd1 : 32'd0);
        end
        serve_frame(0, 8, 0, 2, 9'h000, 1'b0, next_idx, wb);
        checkOutput("single_wb_word", wb, 32'h0040_5800);

        // Reset while BD1 is on offer.
        seen = 0;
        for (int c = 0; c < 50 && seen == 0; c++) begin
            @(negedge clock);
            if (desc_valid) seen = 1;
        end
        checkOutput("bd1_offer", {31'd0, desc_valid}, 32'd1);
        reset_n = 1'b0;
        tx_en   = 1'b0;
        #1;
        checkOutput("midreset_flags", {bd_wren, desc_valid, txb_irq, txe_irq, desc_pad, desc_crc, 26'd0}, 32'd0);
        checkOutput("midreset_len", {16'd0, desc_len}, 32'd0);
        checkOutput("midreset_ptr", desc_ptr, 32'd0);
        checkOutput("midreset_wdata", bd_wdata, 32'd0);
        checkOutput("midreset_addr", {25'd0, bd_address}, 32'd0);
        checkOutput("midreset_cur_bd", {26'd0, cur_bd}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            checkOutput("idle_port_b", {24'd0, bd_wren, bd_address}, 32'd0);
            checkOutput("idle_valid", {31'd0, desc_valid}, 32'd0);
        end

        // Poll on a not-ready BD0 until software sets RD at a random moment.
        mem[0] = 32'h0010_4000;
        mem[1] = 32'h0000_3000;
        mem[2] = 32'h05DC_C000;
        mem[3] = 32'h2000_0040;
        tx_en  = 1'b1;
        s      = $urandom_range(1, 3 * (P + 2));
        r      = 2;
        while (r <= s) r += P + 2;
        exp_n  = r + 3;
        seen   = 0;
        for (int n = 1; n <= exp_n + 6 && seen == 0; n++) begin
            @(negedge clock);
            if (desc_valid) seen = n;
            if (n == s) mem[0][15] = 1'b1;
        end
        checkOutput("poll_latency", seen, exp_n);
        checkOutput("poll_bound", {31'd0, (seen > 0) && (seen - s <= P + 5)}, 32'd1);
        serve_frame(0, 8, 0, 1, 9'($urandom_range(0, 511)), 1'b0, next_idx, wb);

        // Backpressure on BD1, underrun status, tx_en dropped during BUSY.
        serve_frame(1, 8, 10, 3, 9'h100, 1'b1, next_idx, wb);
        checkOutput("err_wb_status", {23'd0, wb[8:0]}, 32'h100);
        stop_engine();

        // Wrap via WR: BD2 must never be fetched.
        tx_bd_num = 7'd4;
        mem[0] = 32'h0100_8000;
        mem[1] = 32'h0000_0100;
        mem[2] = 32'h0200_A000;
        mem[3] = 32'h0000_0200;
        mem[4] = 32'h0300_8000;
        mem[5] = 32'h0000_0300;
        tx_en  = 1'b1;
        serve_frame(0, 4, 1, 0, 9'h000, 1'b0, next_idx, wb);
        serve_frame(1, 4, 0, 1, 9'h000, 1'b0, next_idx, wb);
        checkOutput("wr_wrap_idx", next_idx, 32'd0);
        serve_frame(0, 4, 0, 0, 9'h002, 1'b0, next_idx, wb);
        stop_engine();

        // Wrap via count.
        tx_bd_num = 7'd2;
        rearm(0);
        rearm(1);
        tx_en = 1'b1;
        serve_frame(0, 2, 0, 0, 9'h040, 1'b0, next_idx, wb);
        serve_frame(1, 2, 2, 1, 9'h000, 1'b0, next_idx, wb);
        checkOutput("count_wrap_idx", next_idx, 32'd0);
        stop_engine();

        applyStimulus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule

// File: doc/eth_avalon_txbd_fetch.md
Name: eth_avalon_txbd_fetch

Overview:
- TX buffer-descriptor engine on port B of the dual-port BD RAM; the CPU owns port A.
- Walks the TX descriptor ring and reads each descriptor's two words.
- Hands ready descriptors to the TX DMA through a valid/ready handshake.
- After the frame completes, writes back status, clears the ready bit and raises interrupt pulses.

Parameters:
- DEPTH, 128, BD RAM depth in 32-bit words. AW = log2(DEPTH) (7 at default). Max BDs = DEPTH/2.
- POLL_CYCLES, 16, idle cycles before re-reading a not-ready descriptor. Must be ≥1.

Ports:
- clock  in  1  system clock, shared with BD RAM
- reset_n  in  1  asynchronous, active-low reset
- tx_en  in  1  MODER.TXEN
- tx_bd_num  in  AW  number of TX BDs; values above DEPTH/2 are clamped to DEPTH/2
- bd_address  out  AW  BD RAM port B address (registered)
- bd_wren  out  1  BD RAM port B write enable (registered)
- bd_wdata  out  32  BD RAM port B write data (registered)
- bd_rdata  in  32  BD RAM port B q; valid the cycle after bd_address is presented
- desc_valid  out  1  descriptor offered to DMA
- desc_ready  in  1  DMA accepts descriptor
- desc_len  out  16  frame length (word0[31:16])
- desc_ptr  out  32  buffer pointer (word1)
- desc_pad  out  1  word0[12]
- desc_crc  out  1  word0[11]
- done_valid  in  1  single-cycle pulse: DMA finished the frame
- done_status  in  9  {UR,RL,LC,DF,RTRY[3:0],CS} → word0[8:0]
- txb_irq  out  1  one-cycle pulse: good frame sent, IRQ bit set
- txe_irq  out  1  one-cycle pulse: errored frame, IRQ bit set
- cur_bd  out  AW-1  current BD index (debug/status)

Behaviour:
- Reset: every output is 0, index = 0, FSM in IDLE, poll counter = 0.
- Descriptor layout: BD i occupies word0 at address 2i and word1 at address 2i+1.
- word0 fields: [31:16] LEN, [15] RD, [14] IRQ, [13] WR, [12] PAD, [11] CRC, [8:0] status.
- IDLE:
  - If tx_en=1 and tx_bd_num≠0 → RD0.
  - If tx_en=0: index ← 0 and remain in IDLE.
- RD0: drive bd_address = 2·index → RD0_W.
- RD0_W: capture bd_rdata into the word0 register.
  - If tx_en=0 → IDLE.
  - Else if RD=0 → POLL.
  - Else → RD1 (drive 2·index+1).
- POLL:
  - Count POLL_CYCLES cycles, then → RD0.
  - tx_en=0 aborts to IDLE immediately.
- RD1 → RD1_W: capture word1 into desc_ptr → OFFER.
- OFFER:
  - desc_valid=1; desc_* stay stable until accepted.
  - Transfer completes when desc_valid && desc_ready, then → BUSY.
  - desc_valid drops the next cycle.
  - tx_en=0 while in OFFER → IDLE, no transfer.
- BUSY:
  - Wait for done_valid and latch done_status.
  - tx_en deasserting in BUSY is ignored; the frame always completes.
- WB:
  - One cycle: bd_wren=1, bd_address=2·index.
  - bd_wdata = {LEN, RD=0, IRQ, WR, PAD, CRC, word0[10:9], done_status}.
  - In the same cycle, if IRQ=1: pulse txe_irq if any of UR/RL/LC/CS is set, otherwise pulse txb_irq.
  - Index advance: if WR=1 or index = tx_bd_num−1, index ← 0; else index+1.
  - Next state: → IDLE.
- bd_wren is high only in WB; port B never reads and writes in the same cycle.
- Latency: IDLE to desc_valid for a ready BD = 5 cycles (IDLE, RD0, RD0_W, RD1, RD1_W).
- done_valid outside BUSY is ignored.
- Coherency: software must not write a BD while its RD=1. Mixed-port read-during-write on the RAM is undefined.
- tx_bd_num changing while the engine is active takes effect at the next index advance.

Test Plan:
- Reset then idle: reset_n low mid-OFFER → all outputs 0 within the same cycle, index=0; with tx_en=0 and BD0 RD=1, no port-B activity.
- Single frame: BD0 word0=0x0040_D800 (LEN=64, RD, IRQ, PAD, CRC), word1=0x0000_1000, tx_en=1 → desc_valid at cycle 5 with len=64, ptr=0x1000, pad=1, crc=1; done_status=0 → word0 written 0x0040_5800, txb_irq pulse, cur_bd=1.
- Wrap via WR: tx_bd_num=4, BD1 has WR=1 and RD=1, BD2 RD=1 → after BD1 completes, cur_bd=0 and BD2 is never fetched.
- Wrap via count: tx_bd_num=2, BD0 and BD1 ready with WR=0 → after BD1, cur_bd=0.
- Poll: BD0 RD=0 → reads at address 0 repeat every POLL_CYCLES+2 cycles; CPU sets RD → desc_valid within POLL_CYCLES+5 cycles.
- Error and backpressure: desc_ready held low 10 cycles → desc_* stable throughout; done_status UR set (0x100) with IRQ=1 → txe_irq pulse, txb_irq stays 0, written word0[8:0]=0x100.
